// File: rtl/core_run_initiator_if.sv
// Run-handshake bundle between the host/harness side and core_run_initiator.
// Carries the run request/abort, the core's ack, the core reset/start drives
// and the run result (busy, done pulse, timeout flag, cycle and run counts).
interface core_run_initiator_if #(
  parameter int CNT_W = 16
) ();
  logic             go;
  logic             abort;
  logic             core_ack;
  logic             core_reset;
  logic             core_start;
  logic             busy;
  logic             done;
  logic             timed_out;
  logic [CNT_W-1:0] cycle_count;
  logic [7:0]       run_count;

  // Host / harness side: issues requests, models the core's ack.
  modport master (
    output go, abort, core_ack,
    input  core_reset, core_start, busy, done, timed_out, cycle_count, run_count
  );

  // Initiator side.
  modport slave (
    input  go, abort, core_ack,
    output core_reset, core_start, busy, done, timed_out, cycle_count, run_count
  );
endinterface

// File: rtl/core_run_initiator.sv
// Host-side initiator for the core start/ack run handshake.
// Ports: clk, reset (sync, active-high); run_if (slave): go/abort/core_ack in,
//   core_reset/core_start/busy/done/timed_out/cycle_count/run_count out.
// Sequence: IDLE -> RST (core_reset) -> START (core_start) -> WAIT (count until
//   ack or timeout) -> FINISH (done pulse) -> IDLE. All outputs registered.
module core_run_initiator #(
  parameter int RESET_CYCLES      = 2,
  parameter int START_HOLD_CYCLES = 2,
  parameter int TIMEOUT_CYCLES    = 4096,
  parameter int CNT_W             = 16
) (
  input  logic            clk,
  input  logic            reset,
  core_run_initiator_if.slave run_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_START,
    S_WAIT,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;        // cycles spent in the current state
  logic             r_core_reset;
  logic             r_core_start;
  logic             r_busy;
  logic             r_done;
  logic             r_timed_out;
  logic [CNT_W-1:0] r_cycle_count;
  logic [7:0]       r_run_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_core_reset  <= 1'b0;
      r_core_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timed_out   <= 1'b0;
      r_cycle_count <= '0;
      r_run_count   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (run_if.go) begin
            r_state      <= S_RST;
            r_cnt        <= '0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        S_RST: begin
          if (run_if.abort) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_core_reset <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_cnt == RST_LAST) begin
            r_state      <= S_START;
            r_cnt        <= '0;
            r_core_reset <= 1'b0;
            r_core_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // core_ack is deliberately not looked at: the core is not running yet.
        S_START: begin
          if (run_if.abort) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_core_start <= 1'b0;
            r_busy       <= 1'b0;
          end else if (r_cnt == START_LAST) begin
            r_state      <= S_WAIT;
            r_cnt        <= '0;
            r_core_start <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // Priority: abort, then ack, then timeout. An ack on the last
        // allowed cycle is still a success.
        S_WAIT: begin
          if (run_if.abort) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else if (run_if.core_ack) begin
            r_state       <= S_FINISH;
            r_cycle_count <= r_cnt;
            r_timed_out   <= 1'b0;
            r_done        <= 1'b1;
            r_run_count   <= r_run_count + 8'd1;
          end else if (r_cnt == WAIT_LAST) begin
            r_state       <= S_FINISH;
            r_cycle_count <= TIMEOUT_V;
            r_timed_out   <= 1'b1;
            r_done        <= 1'b1;
            r_run_count   <= r_run_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        // go and abort are both ignored here; the run always completes.
        S_FINISH: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_core_reset <= 1'b0;
          r_core_start <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign run_if.core_reset  = r_core_reset;
  assign run_if.core_start  = r_core_start;
  assign run_if.busy        = r_busy;
  assign run_if.done        = r_done;
  assign run_if.timed_out   = r_timed_out;
  assign run_if.cycle_count = r_cycle_count;
  assign run_if.run_count   = r_run_count;

endmodule

// File: tb/tb_core_run_initiator.sv
module tb_core_run_initiator;
  localparam int R  = 2;
  localparam int S  = 2;
  localparam int T  = 16;
  localparam int CW = 16;
  localparam int W  = R + S + 1;  // cycle index of the first WAIT cycle after go

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  core_run_initiator_if #(.CNT_W(CW)) bus ();

  core_run_initiator #(
    .RESET_CYCLES     (R),
    .START_HOLD_CYCLES(S),
    .TIMEOUT_CYCLES   (T),
    .CNT_W            (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .run_if(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the result registers.
  int exp_rc = 0;
  int exp_cc = 0;
  int exp_to = 0;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== 32'(exp)) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string ph, input int k, input int e_rst, input int e_st,
                            input int e_busy, input int e_done);
    check($sformatf("%s.k%0d.core_reset", ph, k), 32'(bus.core_reset), e_rst);
    check($sformatf("%s.k%0d.core_start", ph, k), 32'(bus.core_start), e_st);
    check($sformatf("%s.k%0d.busy", ph, k), 32'(bus.busy), e_busy);
    check($sformatf("%s.k%0d.done", ph, k), 32'(bus.done), e_done);
    check($sformatf("%s.k%0d.timed_out", ph, k), 32'(bus.timed_out), exp_to);
    check($sformatf("%s.k%0d.cycle_count", ph, k), 32'(bus.cycle_count), exp_cc);
    check($sformatf("%s.k%0d.run_count", ph, k), 32'(bus.run_count), exp_rc);
  endtask

  // One run. Entered just after a rising edge; that cycle is k=0 and go is
  // raised in it. d: WAIT cycle index at which ack rises (>=T means never).
  // abort_at / rst_at: cycle index in which abort / reset is driven (0 = none).
  task automatic do_run(input string ph, input int d, input bit hold_go, input bit ack_start,
                        input int abort_at, input int rst_at);
    int  f, cc_new, to_new, kill, kend;
    bit  active;
    if (d < T) begin
      f = W + d + 1; cc_new = d; to_new = 0;
    end else begin
      f = W + T; cc_new = T; to_new = 1;
    end
    kill = 0;
    if (abort_at > 0 && abort_at < f) kill = abort_at;
    if (rst_at > 0) kill = rst_at;
    kend = (kill > 0) ? kill + 2 : f + 2;

    bus.go    = 1'b1;
    bus.abort = 1'b0;
    for (int k = 1; k <= kend; k++) begin
      @(posedge clk);
      #1;
      active = (kill == 0) || (k <= kill);
      if (kill == 0 && k == f) begin
        exp_rc = (exp_rc + 1) % 256;
        exp_cc = cc_new;
        exp_to = to_new;
      end
      if (rst_at > 0 && k == rst_at + 1) begin
        exp_rc = 0; exp_cc = 0; exp_to = 0;
      end
      check_outs(ph, k,
                 int'(active && k <= R),
                 int'(active && k > R && k <= R + S),
                 int'(active && k <= f),
                 int'(active && k == f));
      // inputs for cycle k
      bus.go       = hold_go && (kill == 0) && (k <= f);
      bus.core_ack = (k >= W + d) || (ack_start && k > R && k <= R + S);
      bus.abort    = (k == abort_at);
      reset        = (k == rst_at);
    end
    bus.go    = 1'b0;
    bus.abort = 1'b0;
    reset     = 1'b0;
  endtask

  initial begin
    int d, ab;
    reset        = 1'b1;
    bus.go       = 1'b0;
    bus.abort    = 1'b0;
    bus.core_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0);

    do_run("basic", 10, 1'b0, 1'b0, 0, 0);
    do_run("abort_wait", 10, 1'b0, 1'b0, W + 3, 0);
    do_run("timeout", 1000, 1'b0, 1'b0, 0, 0);
    do_run("ack_first", 0, 1'b0, 1'b0, 0, 0);
    do_run("ack_last", T - 1, 1'b0, 1'b0, 0, 0);
    do_run("hold_go", 5, 1'b1, 1'b0, 0, 0);
    do_run("ack_in_start", 4, 1'b0, 1'b1, 0, 0);
    do_run("abort_rst", 6, 1'b0, 1'b0, 1, 0);
    do_run("abort_finish", 2, 1'b0, 1'b0, W + 3, 0);
    bus.core_ack = 1'b1;  // stale ack entering the next run
    do_run("stale_ack", 7, 1'b0, 1'b0, 0, 0);
    do_run("reset_start", 4, 1'b0, 1'b0, 0, R + 1);

    for (int i = 0; i < 256; i++) do_run("b2b", 3, 1'b0, 1'b0, 0, 0);
    check("wrap.run_count", 32'(bus.run_count), 0);
    check("wrap.cycle_count", 32'(bus.cycle_count), 3);

    for (int i = 0; i < 60; i++) begin
      d  = $urandom_range(0, 20);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 25) : 0;
      do_run("rand", d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ab, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
